// File: rtl/axi4_rab_pkg.sv
// Types shared by the AXI4 W-channel gate: FSM state encoding and the
// pending-AW queue entry.
package axi4_rab_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  typedef struct packed {
    logic       drop;
    logic [7:0] len;
  } entry_t;

  // Burst state selected by a queued AW decision.
  function automatic state_t entry_state(input entry_t e);
    return e.drop ? ST_DROP : ST_PASS;
  endfunction

endpackage

// File: rtl/axi4_wch_gate_if.sv
// AXI4 W channel bundle. The master modport drives the beat, the slave
// modport accepts it.
interface axi4_wch_gate_if #(
  parameter int DATA_W = 64,
  parameter int USER_W = 4
);
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic [USER_W-1:0]   wuser;
  logic                wvalid;
  logic                wready;

  modport master (output wdata, wstrb, wlast, wuser, wvalid, input wready);
  modport slave  (input wdata, wstrb, wlast, wuser, wvalid, output wready);
endinterface

// File: rtl/axi4_wch_gate_fifo.sv
// Pending-AW decision queue. Exposes the head entry and the one behind it
// so the gate can move straight into the next burst without a bubble.
module axi4_wch_gate_fifo
  import axi4_rab_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  entry_t                   din,
  output logic                     full,
  output logic                     empty,
  output entry_t                   head,
  output entry_t                   head_next,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A push while full is dropped even if the same cycle pops.
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign head      = mem[rd_ptr];
  assign head_next = mem[AW'(rd_ptr + 1'b1)];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= AW'(wr_ptr + 1'b1);
      if (do_pop)  rd_ptr <= AW'(rd_ptr + 1'b1);
      case ({do_push, do_pop})
        2'b10:   count <= CW'(count + 1'b1);
        2'b01:   count <= CW'(count - 1'b1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are qualified by count, so no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/axi4_wch_gate.sv
// AXI4 W-channel gate: forwards or discards W bursts in the order of the
// AW decisions queued by the AW sender.
// Optional macro AXI4_WCH_LEN_CHECK_EN adds a beat counter that flags
// (sticky len_err) any burst whose wlast disagrees with its awlen.
module axi4_wch_gate
  import axi4_rab_pkg::*;
#(
  parameter int C_AXI_DATA_WIDTH = 64,
  parameter int C_AXI_USER_WIDTH = 4,
  parameter int C_DEPTH          = 4
) (
  input  logic                   axi4_aclk,
  input  logic                   axi4_arst,
  input  logic                   aw_push,
  input  logic                   aw_drop,
  input  logic [7:0]             aw_len,
  output logic                   stall_aw,
  axi4_wch_gate_if.slave         s_axi4,
  axi4_wch_gate_if.master        m_axi4,
  output logic                   wdrop_done,
  output logic                   len_err
);
  localparam int CW = $clog2(C_DEPTH) + 1;

  state_t        state;
  state_t        state_nxt;
  entry_t        head;
  entry_t        head_next;
  entry_t        din;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          hs;
  logic          burst_end;

  assign din       = '{drop: aw_drop, len: aw_len};
  assign stall_aw  = full;
  assign hs        = s_axi4.wvalid & s_axi4.wready;
  assign burst_end = hs & s_axi4.wlast;

  axi4_wch_gate_fifo #(.DEPTH(C_DEPTH)) u_fifo (
    .clk       (axi4_aclk),
    .rst       (axi4_arst),
    .push      (aw_push),
    .pop       (burst_end),
    .din       (din),
    .full      (full),
    .empty     (empty),
    .head      (head),
    .head_next (head_next),
    .count     (count)
  );

  // Beat payload always flows through; only the handshake is gated.
  assign m_axi4.wdata = s_axi4.wdata[C_AXI_DATA_WIDTH-1:0];
  assign m_axi4.wstrb = s_axi4.wstrb[C_AXI_DATA_WIDTH/8-1:0];
  assign m_axi4.wlast = s_axi4.wlast;
  assign m_axi4.wuser = s_axi4.wuser[C_AXI_USER_WIDTH-1:0];

  // State register.
  always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
    if (axi4_arst) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // Next state: start on a queued entry, chain into the following one on wlast.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (!empty) state_nxt = entry_state(head);
      end
      ST_PASS, ST_DROP: begin
        if (burst_end)
          state_nxt = (count > CW'(1)) ? entry_state(head_next) : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Handshake gating per state.
  always_comb begin
    m_axi4.wvalid = 1'b0;
    s_axi4.wready = 1'b0;
    wdrop_done    = 1'b0;
    unique case (state)
      ST_PASS: begin
        m_axi4.wvalid = s_axi4.wvalid;
        s_axi4.wready = m_axi4.wready;
      end
      ST_DROP: begin
        s_axi4.wready = 1'b1;
        wdrop_done    = s_axi4.wvalid & s_axi4.wlast;
      end
      default: ;
    endcase
  end

`ifdef AXI4_WCH_LEN_CHECK_EN
  logic [7:0] beat_cnt;
  logic       len_err_q;
  logic       unused_len;

  assign unused_len = ^head_next.len;
  assign len_err    = len_err_q;

  // Beat counter restarts after each wlast; a mismatch between wlast and
  // the expected final beat (count == len) latches len_err until reset.
  always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
    if (axi4_arst) begin
      beat_cnt  <= 8'd0;
      len_err_q <= 1'b0;
    end else if (hs) begin
      beat_cnt <= s_axi4.wlast ? 8'd0 : beat_cnt + 8'd1;
      if (s_axi4.wlast != (beat_cnt == head.len)) len_err_q <= 1'b1;
    end
  end
`else
  logic unused_len;

  assign unused_len = ^{head.len, head_next.len};
  assign len_err    = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_wch_gate.sv
// Directed bench for axi4_wch_gate (default C_DEPTH=4).
module tb_axi4_wch_gate;
  localparam int DW = 64;
  localparam int UW = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       aw_push;
  logic       aw_drop;
  logic [7:0] aw_len;
  logic       stall_aw;
  logic       wdrop_done;
  logic       len_err;
  logic       exp_len_err;

  int total = 0;
  int bad   = 0;

  axi4_wch_gate_if #(.DATA_W(DW), .USER_W(UW)) s_if ();
  axi4_wch_gate_if #(.DATA_W(DW), .USER_W(UW)) m_if ();

  always #5 clk = ~clk;

  axi4_wch_gate #(
    .C_AXI_DATA_WIDTH (DW),
    .C_AXI_USER_WIDTH (UW),
    .C_DEPTH          (4)
  ) dut (
    .axi4_aclk  (clk),
    .axi4_arst  (rst),
    .aw_push    (aw_push),
    .aw_drop    (aw_drop),
    .aw_len     (aw_len),
    .stall_aw   (stall_aw),
    .s_axi4     (s_if),
    .m_axi4     (m_if),
    .wdrop_done (wdrop_done),
    .len_err    (len_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [63:0] d, input logic last);
    s_if.wdata  = d;
    s_if.wstrb  = 8'hFF;
    s_if.wlast  = last;
    s_if.wvalid = 1'b1;
  endtask

  initial begin
`ifdef AXI4_WCH_LEN_CHECK_EN
    exp_len_err = 1'b1;
`else
    exp_len_err = 1'b0;
`endif
    rst = 1'b1; aw_push = 1'b0; aw_drop = 1'b0; aw_len = 8'd0;
    s_if.wdata = '0; s_if.wstrb = '0; s_if.wlast = 1'b0;
    s_if.wuser = '0; s_if.wvalid = 1'b0; m_if.wready = 1'b0;

    // Reset state
    tick();
    chk("rst_stall", stall_aw, 1'b0);
    chk("rst_len_err", len_err, 1'b0);
    chk("rst_wdrop_done", wdrop_done, 1'b0);
    chk("rst_s_wready", s_if.wready, 1'b0);
    chk("rst_m_wvalid", m_if.wvalid, 1'b0);
    tick();
    rst = 1'b0;

    // Pass burst, len=3
    aw_push = 1'b1; aw_drop = 1'b0; aw_len = 8'd3;
    tick();
    aw_push = 1'b0;
    m_if.wready = 1'b1; s_if.wuser = 4'h5;
    beat(64'h100, 1'b0);
    #1;
    chk("lat_m_wvalid", m_if.wvalid, 1'b0);
    chk("lat_s_wready", s_if.wready, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      beat(64'h100 + 64'(i), i == 3);
      #1;
      chk("pass_m_wvalid", m_if.wvalid, 1'b1);
      chk("pass_m_wdata", m_if.wdata, 64'h100 + 64'(i));
      chk("pass_m_wlast", m_if.wlast, (i == 3) ? 1'b1 : 1'b0);
      chk("pass_m_wuser", m_if.wuser, 4'h5);
      tick();
    end
    chk("pass_end_m_wvalid", m_if.wvalid, 1'b0);
    chk("pass_end_s_wready", s_if.wready, 1'b0);
    chk("pass_end_len_err", len_err, 1'b0);
    s_if.wvalid = 1'b0; s_if.wlast = 1'b0;

    // Dropped burst, len=1; downstream not ready to show it is ignored
    aw_push = 1'b1; aw_drop = 1'b1; aw_len = 8'd1;
    tick();
    aw_push = 1'b0; m_if.wready = 1'b0;
    tick();
    beat(64'hD0, 1'b0);
    #1;
    chk("drop0_m_wvalid", m_if.wvalid, 1'b0);
    chk("drop0_s_wready", s_if.wready, 1'b1);
    chk("drop0_wdrop_done", wdrop_done, 1'b0);
    tick();
    beat(64'hD1, 1'b1);
    #1;
    chk("drop1_m_wvalid", m_if.wvalid, 1'b0);
    chk("drop1_s_wready", s_if.wready, 1'b1);
    chk("drop1_wdrop_done", wdrop_done, 1'b1);
    tick();
    s_if.wvalid = 1'b0; s_if.wlast = 1'b0;
    #1;
    chk("drop_end_wdrop_done", wdrop_done, 1'b0);
    chk("drop_end_s_wready", s_if.wready, 1'b0);

    // Fill the queue, fifth push while full must be ignored
    aw_push = 1'b1;
    aw_drop = 1'b0; aw_len = 8'd0; tick();
    aw_drop = 1'b1; aw_len = 8'd0; tick();
    aw_drop = 1'b0; aw_len = 8'd1; tick();
    aw_drop = 1'b0; aw_len = 8'd0; tick();
    chk("full_stall", stall_aw, 1'b1);
    aw_drop = 1'b1; aw_len = 8'd0; tick();
    aw_push = 1'b0;
    #1;
    chk("full_stall_after_5th", stall_aw, 1'b1);

    // Drain back-to-back: pass, drop, pass(2 beats), pass
    m_if.wready = 1'b1;
    beat(64'hE0, 1'b1);
    #1;
    chk("b2b0_m_wvalid", m_if.wvalid, 1'b1);
    chk("b2b0_m_wdata", m_if.wdata, 64'hE0);
    tick();
    beat(64'hE1, 1'b1);
    #1;
    chk("b2b1_stall", stall_aw, 1'b0);
    chk("b2b1_m_wvalid", m_if.wvalid, 1'b0);
    chk("b2b1_s_wready", s_if.wready, 1'b1);
    chk("b2b1_wdrop_done", wdrop_done, 1'b1);
    tick();
    beat(64'hE2, 1'b0);
    #1;
    chk("b2b2_m_wvalid", m_if.wvalid, 1'b1);
    tick();
    beat(64'hE3, 1'b1);
    #1;
    chk("b2b3_m_wvalid", m_if.wvalid, 1'b1);
    chk("b2b3_m_wlast", m_if.wlast, 1'b1);
    tick();
    beat(64'hE4, 1'b1);
    #1;
    chk("b2b4_m_wvalid", m_if.wvalid, 1'b1);
    chk("b2b4_m_wdata", m_if.wdata, 64'hE4);
    tick();
    chk("drained_m_wvalid", m_if.wvalid, 1'b0);
    chk("drained_s_wready", s_if.wready, 1'b0);
    tick();
    chk("drained2_s_wready", s_if.wready, 1'b0);
    s_if.wvalid = 1'b0; s_if.wlast = 1'b0;

    // len=3 burst terminated early by wlast on beat 2
    aw_push = 1'b1; aw_drop = 1'b0; aw_len = 8'd3;
    tick();
    aw_push = 1'b0;
    tick();
    beat(64'hF0, 1'b0);
    tick();
    beat(64'hF1, 1'b1);
    #1;
    chk("short_m_wlast", m_if.wlast, 1'b1);
    tick();
    s_if.wvalid = 1'b0; s_if.wlast = 1'b0;
    #1;
    chk("short_len_err", len_err, exp_len_err);
    chk("short_s_wready", s_if.wready, 1'b0);
    tick();
    tick();
    chk("short_len_err_sticky", len_err, exp_len_err);

    // Reset in the middle of a len=7 pass burst
    aw_push = 1'b1; aw_drop = 1'b0; aw_len = 8'd7;
    tick();
    aw_push = 1'b0;
    tick();
    beat(64'hA0, 1'b0);
    #1;
    chk("mid_b0_m_wvalid", m_if.wvalid, 1'b1);
    tick();
    beat(64'hA1, 1'b0);
    #1;
    chk("mid_b1_m_wvalid", m_if.wvalid, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_m_wvalid", m_if.wvalid, 1'b0);
    chk("mid_rst_s_wready", s_if.wready, 1'b0);
    chk("mid_rst_stall", stall_aw, 1'b0);
    chk("mid_rst_len_err", len_err, 1'b0);
    chk("mid_rst_wdrop_done", wdrop_done, 1'b0);
    tick();
    rst = 1'b0;
    for (int i = 2; i < 5; i++) begin
      beat(64'hA0 + 64'(i), 1'b0);
      #1;
      chk("post_rst_m_wvalid", m_if.wvalid, 1'b0);
      chk("post_rst_s_wready", s_if.wready, 1'b0);
      tick();
    end
    s_if.wvalid = 1'b0;

    // Fresh transaction after reset forwards again
    aw_push = 1'b1; aw_drop = 1'b0; aw_len = 8'd0;
    tick();
    aw_push = 1'b0;
    tick();
    beat(64'hB0, 1'b1);
    #1;
    chk("recover_m_wvalid", m_if.wvalid, 1'b1);
    chk("recover_m_wdata", m_if.wdata, 64'hB0);
    tick();
    s_if.wvalid = 1'b0; s_if.wlast = 1'b0;
    #1;
    chk("recover_idle_s_wready", s_if.wready, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
